// File: rtl/core_status_regs.sv
// core_status_regs: APB3 slave holding the firmware end-of-computation
// status word, a free-running 64-bit cycle counter and a watchdog that
// forces a failure code when firmware stops kicking it.
module core_status_regs #(
  parameter int          ADDR_W          = 12,
  parameter logic [30:0] WDT_FAIL_CODE   = 31'h7FFF_FFFF,
  parameter logic [31:0] WDT_RESET_LIMIT = 32'd0
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              eoc_o,
  output logic [30:0]       exit_code_o,
  output logic              wdt_expired_o
);

  localparam logic [2:0] REG_STATUS    = 3'd0;
  localparam logic [2:0] REG_CYCLE_LO  = 3'd1;
  localparam logic [2:0] REG_CYCLE_HI  = 3'd2;
  localparam logic [2:0] REG_WDT_LIMIT = 3'd3;
  localparam logic [2:0] REG_WDT_KICK  = 3'd4;
  localparam logic [2:0] REG_CTRL      = 3'd5;

  logic        done;
  logic [30:0] code;
  logic        wdt_expired;
  logic [63:0] cycle_cnt;
  logic [31:0] hi_snap;
  logic [31:0] wdt_limit;
  logic [31:0] wdt_cnt;

  logic [2:0]  reg_idx;
  logic        addr_ok;
  logic        setup_phase;
  logic        access_phase;
  logic        wr_en;
  logic        wr_status;
  logic        wr_limit;
  logic        wr_kick;
  logic        wr_ctrl;
  logic        ctrl_clear;
  logic        ctrl_zero;
  logic        wdt_kick;
  logic        wdt_active;
  logic        wdt_expire;
  logic [31:0] rd_data;
  logic        unused_addr;

  // Only word offsets 0x00..0x14 exist; byte lanes are ignored.
  assign reg_idx      = paddr[4:2];
  assign addr_ok      = (paddr[ADDR_W-1:5] == '0) && (reg_idx <= REG_CTRL);
  assign unused_addr  = ^paddr[1:0];

  assign setup_phase  = psel && !penable;
  assign access_phase = psel && penable;
  assign wr_en        = access_phase && pwrite && addr_ok;
  assign wr_status    = wr_en && (reg_idx == REG_STATUS);
  assign wr_limit     = wr_en && (reg_idx == REG_WDT_LIMIT);
  assign wr_kick      = wr_en && (reg_idx == REG_WDT_KICK);
  assign wr_ctrl      = wr_en && (reg_idx == REG_CTRL);
  assign ctrl_clear   = wr_ctrl && pwdata[0];
  assign ctrl_zero    = wr_ctrl && pwdata[1];

  // Writing the limit restarts the count just like a kick does.
  assign wdt_kick     = wr_kick || wr_limit;
  assign wdt_active   = (wdt_limit != 32'd0) && !done;
  assign wdt_expire   = wdt_active && (wdt_cnt == wdt_limit - 32'd1) && !wdt_kick;

  assign pready        = 1'b1;
  assign eoc_o         = done;
  assign exit_code_o   = code;
  assign wdt_expired_o = wdt_expired;

  // Read mux; write-only and reserved offsets read as zero.
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_STATUS:    rd_data = {done, code};
      REG_CYCLE_LO:  rd_data = cycle_cnt[31:0];
      REG_CYCLE_HI:  rd_data = hi_snap;
      REG_WDT_LIMIT: rd_data = wdt_limit;
      default:       rd_data = '0;
    endcase
  end

  // Register the read response in the setup cycle; a CYCLE_LO read also latches the upper half.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      prdata  <= '0;
      pslverr <= 1'b0;
      hi_snap <= '0;
    end else if (setup_phase) begin
      pslverr <= !addr_ok;
      prdata  <= (!pwrite && addr_ok) ? rd_data : '0;
      if (!pwrite && addr_ok && (reg_idx == REG_CYCLE_LO)) begin
        hi_snap <= cycle_cnt[63:32];
      end
    end else begin
      prdata  <= '0;
      pslverr <= 1'b0;
    end
  end

  // Cycle counter runs until the EOC flag is set and can be zeroed through CTRL.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
    end else if (ctrl_zero) begin
      cycle_cnt <= '0;
    end else if (!done) begin
      cycle_cnt <= cycle_cnt + 64'd1;
    end
  end

  // Watchdog limit register and counter; the counter idles at zero when disarmed.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wdt_limit <= WDT_RESET_LIMIT;
      wdt_cnt   <= '0;
    end else begin
      if (wr_limit) begin
        wdt_limit <= pwdata;
      end
      if (!wdt_active || wdt_kick || wdt_expire) begin
        wdt_cnt <= '0;
      end else begin
        wdt_cnt <= wdt_cnt + 32'd1;
      end
    end
  end

  // STATUS is write-once; clear beats everything, a firmware EOC beats expiry.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      done        <= 1'b0;
      code        <= '0;
      wdt_expired <= 1'b0;
    end else if (ctrl_clear) begin
      done        <= 1'b0;
      code        <= '0;
      wdt_expired <= 1'b0;
    end else if (wr_status && !done && pwdata[31]) begin
      done <= 1'b1;
      code <= pwdata[30:0];
    end else if (wdt_expire) begin
      done        <= 1'b1;
      code        <= WDT_FAIL_CODE;
      wdt_expired <= 1'b1;
    end else if (wr_status && !done) begin
      code <= pwdata[30:0];
    end
  end

endmodule

// File: tb/tb_core_status_regs.sv
// tb_core_status_regs: directed and randomized checks of core_status_regs
// against a cycle-level behavioural model of the register block.
module tb_core_status_regs;

  localparam logic [30:0] FAIL_CODE = 31'h7FFF_FFFF;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        eoc_o;
  logic [30:0] exit_code_o;
  logic        wdt_expired_o;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit              m_done;
  logic [30:0]     m_code;
  bit              m_exp;
  longint unsigned m_cyc;
  logic [31:0]     m_snap;
  logic [31:0]     m_limit;
  logic [31:0]     m_wdt;
  logic [31:0]     m_prdata;
  bit              m_slverr;

  core_status_regs dut (
    .clk_in        (clk_in),
    .reset_n       (reset_n),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pready        (pready),
    .pslverr       (pslverr),
    .eoc_o         (eoc_o),
    .exit_code_o   (exit_code_o),
    .wdt_expired_o (wdt_expired_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_reset();
    m_done = 0; m_code = '0; m_exp = 0; m_cyc = 0; m_snap = '0;
    m_limit = '0; m_wdt = '0; m_prdata = '0; m_slverr = 0;
  endtask

  // Advance one clock: apply the register-map rules to the model, then move to the next falling edge.
  task automatic step();
    bit              valid, wr, kick, expire, clr;
    logic [2:0]      idx;
    logic [31:0]     rd;
    longint unsigned n_cyc;
    logic [31:0]     n_wdt, n_limit;
    bit              n_done, n_exp;
    logic [30:0]     n_code;
    idx   = paddr[4:2];
    valid = (paddr[11:5] == 7'd0) && (idx < 3'd6);
    wr    = psel && penable && pwrite && valid;
    if (psel && !penable) begin
      rd = '0;
      if (!pwrite && valid) begin
        case (idx)
          3'd0: rd = {m_done, m_code};
          3'd1: begin rd = m_cyc[31:0]; m_snap = m_cyc[63:32]; end
          3'd2: rd = m_snap;
          3'd3: rd = m_limit;
          default: rd = '0;
        endcase
      end
      m_prdata = rd;
      m_slverr = !valid;
    end else begin
      m_prdata = '0;
      m_slverr = 0;
    end
    kick   = wr && (idx == 3'd3 || idx == 3'd4);
    expire = (m_limit != 0) && !m_done && (m_wdt + 32'd1 == m_limit) && !kick;
    clr    = wr && (idx == 3'd5) && pwdata[0];
    if (wr && idx == 3'd5 && pwdata[1]) n_cyc = 0;
    else if (m_done) n_cyc = m_cyc;
    else n_cyc = m_cyc + 1;
    n_wdt   = (m_limit != 0 && !m_done && !kick && !expire) ? m_wdt + 32'd1 : 32'd0;
    n_limit = (wr && idx == 3'd3) ? pwdata : m_limit;
    n_done = m_done; n_code = m_code; n_exp = m_exp;
    if (clr) begin
      n_done = 0; n_code = '0; n_exp = 0;
    end else if (wr && idx == 3'd0 && !m_done && pwdata[31]) begin
      n_done = 1; n_code = pwdata[30:0];
    end else if (expire) begin
      n_done = 1; n_code = FAIL_CODE; n_exp = 1;
    end else if (wr && idx == 3'd0 && !m_done) begin
      n_code = pwdata[30:0];
    end
    m_cyc = n_cyc; m_wdt = n_wdt; m_limit = n_limit;
    m_done = n_done; m_code = n_code; m_exp = n_exp;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    reset_n = 0;
    @(posedge clk_in);
    @(negedge clk_in);
    model_reset();
    reset_n = 1;
  endtask

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    psel = 1; penable = 0; pwrite = 1; paddr = addr; pwdata = data;
    step();
    penable = 1;
    step();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic err,
                          output logic [31:0] exp_data, output logic exp_err);
    psel = 1; penable = 0; pwrite = 0; paddr = addr;
    step();
    penable = 1;
    data = prdata; err = pslverr; exp_data = m_prdata; exp_err = m_slverr;
    step();
    psel = 0; penable = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d, ed;
    logic e, ee;
    checks++; if (pready !== 1'b1) begin errors++; $display("[TB] FAIL reset_pready: got %b expected 1", pready); end
    checks++; if (eoc_o !== 1'b0 || exit_code_o !== 31'd0 || wdt_expired_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_outputs: got eoc=%b code=%h exp=%b expected 0/0/0", eoc_o, exit_code_o, wdt_expired_o); end
    apb_read(12'h000, d, e, ed, ee);
    checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("[TB] FAIL reset_status_read: got %h/%b expected 00000000/0", d, e); end
    apb_read(12'h00C, d, e, ed, ee);
    checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("[TB] FAIL reset_wdt_limit: got %h/%b expected 00000000/0", d, e); end
  endtask

  task automatic test_status_write_once();
    logic [31:0] d, ed;
    logic e, ee;
    apb_write(12'h000, 32'h8000_0000);
    checks++; if (eoc_o !== 1'b1 || exit_code_o !== 31'd0) begin
      errors++; $display("[TB] FAIL status_first_write: got eoc=%b code=%h expected 1/0", eoc_o, exit_code_o); end
    apb_write(12'h000, 32'h8000_0005);
    apb_read(12'h000, d, e, ed, ee);
    checks++; if (d !== 32'h8000_0000 || d !== ed) begin
      errors++; $display("[TB] FAIL status_write_once: got %h expected 80000000", d); end
    apb_write(12'h014, 32'h1);
    apb_read(12'h000, d, e, ed, ee);
    checks++; if (d !== 32'h0 || eoc_o !== 1'b0) begin
      errors++; $display("[TB] FAIL status_clear: got %h eoc=%b expected 00000000 eoc=0", d, eoc_o); end
  endtask

  task automatic test_cycle_counter();
    logic [31:0] d, ed, a, b;
    logic e, ee;
    apb_write(12'h00C, 32'h0);
    apb_write(12'h014, 32'h3);
    idle(1000);
    apb_read(12'h004, d, e, ed, ee);
    checks++; if (d !== 32'd1000 || d !== ed) begin errors++; $display("[TB] FAIL cycle_after_1000: got %0d expected %0d", d, ed); end
    apb_write(12'h000, 32'h8000_0003);
    apb_read(12'h004, a, e, ed, ee);
    checks++; if (a !== ed) begin errors++; $display("[TB] FAIL cycle_frozen_first: got %h expected %h", a, ed); end
    idle(50);
    apb_read(12'h004, b, e, ed, ee);
    checks++; if (b !== a) begin errors++; $display("[TB] FAIL cycle_frozen: got %h expected %h", b, a); end
    apb_write(12'h014, 32'h1);
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    m_cyc = 64'h0000_0000_FFFF_FFFE;
    apb_read(12'h004, d, e, ed, ee);
    checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL cycle_lo_pre_carry: got %h expected fffffffe", d); end
    apb_read(12'h008, d, e, ed, ee);
    checks++; if (d !== 32'h0 || d !== ed) begin errors++; $display("[TB] FAIL cycle_hi_snapshot: got %h expected 00000000", d); end
    apb_read(12'h004, d, e, ed, ee);
    checks++; if (d !== 32'h2 || d !== ed) begin errors++; $display("[TB] FAIL cycle_lo_post_carry: got %h expected 00000002", d); end
    apb_read(12'h008, d, e, ed, ee);
    checks++; if (d !== 32'h1 || d !== ed) begin errors++; $display("[TB] FAIL cycle_hi_carry: got %h expected 00000001", d); end
  endtask

  task automatic test_watchdog();
    logic [31:0] d, ed;
    logic e, ee;
    int k;
    bit early;
    apb_write(12'h00C, 32'd100);
    k = 0;
    while (eoc_o !== 1'b1 && k < 200) begin step(); k++; end
    checks++; if (k != 100) begin errors++; $display("[TB] FAIL wdt_expiry_time: got %0d cycles expected 100", k); end
    apb_read(12'h000, d, e, ed, ee);
    checks++; if (d !== 32'hFFFF_FFFF || wdt_expired_o !== 1'b1) begin
      errors++; $display("[TB] FAIL wdt_expiry_status: got %h exp=%b expected ffffffff exp=1", d, wdt_expired_o); end
    apb_write(12'h014, 32'h1);
    early = 0;
    for (int i = 0; i < 20; i++) begin
      apb_write(12'h010, 32'h0);
      idle(48);
      if (eoc_o !== 1'b0) early = 1;
    end
    checks++; if (early || m_done) begin errors++; $display("[TB] FAIL wdt_kicked: got eoc seen=%b expected 0", early); end
  endtask

  task automatic test_simultaneous();
    apb_write(12'h00C, 32'd20);
    idle(18);
    apb_write(12'h010, 32'h0);
    idle(5);
    checks++; if (eoc_o !== 1'b0 || m_done) begin errors++; $display("[TB] FAIL kick_on_expiry: got eoc=%b expected 0", eoc_o); end
    apb_write(12'h00C, 32'd20);
    idle(18);
    apb_write(12'h000, 32'h8000_0042);
    checks++; if (eoc_o !== 1'b1 || exit_code_o !== 31'h42 || wdt_expired_o !== 1'b0) begin
      errors++; $display("[TB] FAIL fw_beats_expiry: got eoc=%b code=%h exp=%b expected 1/00000042/0", eoc_o, exit_code_o, wdt_expired_o); end
    apb_write(12'h014, 32'h1);
    idle(18);
    apb_write(12'h014, 32'h1);
    checks++; if (eoc_o !== 1'b0 || wdt_expired_o !== 1'b0 || m_done) begin
      errors++; $display("[TB] FAIL clear_beats_expiry: got eoc=%b exp=%b expected 0/0", eoc_o, wdt_expired_o); end
    apb_write(12'h00C, 32'h0);
  endtask

  task automatic test_bad_access();
    logic [31:0] d, ed;
    logic e, ee;
    logic [11:0] bad [4];
    bad[0] = 12'h018; bad[1] = 12'h01C; bad[2] = 12'h020; bad[3] = 12'h80C;
    for (int i = 0; i < 4; i++) begin
      apb_read(bad[i], d, e, ed, ee);
      checks++; if (d !== 32'h0 || e !== 1'b1) begin
        errors++; $display("[TB] FAIL bad_read_%0d: got %h/%b expected 00000000/1", i, d, e); end
    end
    apb_write(12'h018, 32'h8000_0077);
    apb_write(12'h020, 32'h8000_0055);
    apb_write(12'h82C, 32'h0000_0064);
    apb_read(12'h000, d, e, ed, ee);
    checks++; if (d !== 32'h0 || e !== 1'b0 || eoc_o !== 1'b0) begin
      errors++; $display("[TB] FAIL bad_write_status: got %h/%b expected 00000000/0", d, e); end
    apb_read(12'h00C, d, e, ed, ee);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL bad_write_limit: got %h expected 00000000", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, ed;
    logic e, ee;
    logic [11:0] a;
    int op;
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 11);
      case (op)
        0, 1, 2, 3: begin
          a = {7'd0, 3'($urandom_range(0, 7)), 2'b00};
          if ($urandom_range(0, 9) == 0) a[11:5] = 7'($urandom_range(1, 127));
          apb_read(a, d, e, ed, ee);
          checks++; if (d !== ed || e !== ee) begin
            errors++; $display("[TB] FAIL rand_read @%h: got %h/%b expected %h/%b", a, d, e, ed, ee); end
        end
        4: apb_write(12'h000, $urandom);
        5: apb_write(12'h010, $urandom);
        6: apb_write(12'h00C, 32'($urandom_range(0, 30)));
        7, 8: apb_write(12'h014, 32'($urandom_range(0, 3)));
        9: apb_write({7'($urandom_range(1, 127)), 3'($urandom_range(0, 7)), 2'b00}, $urandom);
        default: idle($urandom_range(1, 8));
      endcase
      checks++; if (eoc_o !== m_done || exit_code_o !== m_code || wdt_expired_o !== m_exp) begin
        errors++; $display("[TB] FAIL rand_outputs: got %b/%h/%b expected %b/%h/%b",
                           eoc_o, exit_code_o, wdt_expired_o, m_done, m_code, m_exp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, ed;
    logic e, ee;
    apb_write(12'h014, 32'h1);
    apb_write(12'h000, 32'h0000_0009);
    psel = 1; penable = 0; pwrite = 1; paddr = 12'h000; pwdata = 32'h8000_1234;
    step();
    penable = 1;
    reset_n = 0;
    #1;
    checks++; if (eoc_o !== 1'b0 || exit_code_o !== 31'd0 || wdt_expired_o !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid_outputs: got eoc=%b code=%h exp=%b prdata=%h err=%b expected all 0",
                         eoc_o, exit_code_o, wdt_expired_o, prdata, pslverr); end
    @(posedge clk_in);
    @(negedge clk_in);
    psel = 0; penable = 0; pwrite = 0;
    model_reset();
    reset_n = 1;
    apb_read(12'h000, d, e, ed, ee);
    checks++; if (d !== 32'h0 || eoc_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_status: got %h expected 00000000", d); end
  endtask

  // Run each scenario in order and report the totals.
  initial begin
    model_reset();
    @(negedge clk_in);
    do_reset();
    test_reset();
    test_status_write_once();
    test_cycle_counter();
    test_watchdog();
    test_simultaneous();
    test_bad_access();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_status_regs.md
Name: core_status_regs

Overview:
- APB3 slave in the SysCtrl subsystem holding the software end-of-computation (EOC) status word, a free-running cycle counter, and a watchdog.
- Mapped at base 0x0102_0380. The bench and the debug module poll STATUS over JTAG system-bus reads (offset 0x00) until bit 31 is set.
- Firmware writes its exit code here. The watchdog forces a failure code if firmware hangs.

Parameters:
- ADDR_W, 12, APB address width; only paddr[4:2] is decoded, paddr[ADDR_W-1:5] must be zero.
- WDT_FAIL_CODE, 31'h7FFF_FFFF, exit code loaded on watchdog expiry.
- WDT_RESET_LIMIT, 32'd0, WDT_LIMIT value after reset (0 = disabled).

Ports:
- clk_in  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB write
- paddr  in  ADDR_W  APB byte address
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  APB ready
- pslverr  out  1  APB error
- eoc_o  out  1  mirror of STATUS.done
- exit_code_o  out  31  mirror of STATUS.code
- wdt_expired_o  out  1  sticky; watchdog caused current EOC

Behaviour:
- Reset (reset_n low, async): STATUS=0, cycle counter=0, HI snapshot=0, WDT_LIMIT=WDT_RESET_LIMIT, WDT counter=0, prdata=0, pslverr=0, eoc_o=0, exit_code_o=0, wdt_expired_o=0. pready=1 always.
- APB access phase = psel&penable. Zero wait states. prdata and pslverr are registered in the setup cycle (psel&!penable) and are valid during the access cycle. prdata=0 when not reading.
- Register map (word offsets):
  - 0x00 STATUS: [31] done, [30:0] code.
  - 0x04 CYCLE_LO.
  - 0x08 CYCLE_HI.
  - 0x0C WDT_LIMIT.
  - 0x10 WDT_KICK (WO, reads 0).
  - 0x14 CTRL (WO, reads 0).
  - 0x18 and 0x1C, and any nonzero upper address bits: pslverr=1, writes dropped, read 0.
- STATUS write:
  - If done=0: done<=pwdata[31], code<=pwdata[30:0] (written whether or not bit 31 is set).
  - If done=1: write ignored, no error. STATUS is write-once until cleared.
- CTRL write bit0=1 clears done, code, and wdt_expired in the next cycle. Bit1=1 zeros the cycle counter. Other bits ignored.
- Cycle counter: 64-bit, +1 per clock while done=0, frozen while done=1, wraps 2^64-1 -> 0.
  - A CYCLE_LO read captures the upper 32 bits into the HI snapshot in the same cycle.
  - CYCLE_HI reads return the snapshot, giving tear-free LO-then-HI reads.
- Watchdog: active when WDT_LIMIT != 0 and done=0.
  - Counter +1 per clock while active; held at 0 when inactive.
  - Any WDT_KICK write, or any WDT_LIMIT write, zeros the counter.
  - When counter == WDT_LIMIT-1 and no kick that cycle: next cycle done=1, code=WDT_FAIL_CODE, wdt_expired=1, counter=0.
- Simultaneous events in one cycle:
  - Kick beats expiry.
  - Firmware STATUS write with bit31=1 beats expiry; wdt_expired stays 0.
  - CTRL clear and expiry together: clear wins, counter zeroed.
  - CTRL clear and STATUS write in the same cycle cannot occur (single APB port).
- eoc_o and exit_code_o are combinational from the STATUS flops (zero added latency).
- Reset asserted mid-transaction aborts it. No partial register update survives.

Test Plan:
- Reset then read 0x0102_0380 -> prdata=0x0000_0000, pslverr=0. Read 0x0C -> 0x0 (WDT disabled).
- Write STATUS=0x8000_0000 -> eoc_o=1, exit_code_o=0. Second write 0x8000_0005 -> STATUS still reads 0x8000_0000. CTRL=1 -> STATUS reads 0, eoc_o=0.
- After 1000 clocks with done=0: read CYCLE_LO ≈1000. Write STATUS=0x8000_0003 -> two CYCLE_LO reads 50 cycles apart are equal. Preload counter to 0x0000_0000_FFFF_FFFE via force -> LO/HI reads show carry into HI, HI matches LO snapshot.
- WDT_LIMIT=100, no kicks -> eoc_o rises exactly 100 cycles after the write completes, STATUS=0xFFFF_FFFF, wdt_expired_o=1. Repeat kicking every 50 cycles for 1000 cycles -> no expiry.
- Kick issued on the expiry cycle -> no expiry. STATUS bit31 write on the expiry cycle -> firmware code retained, wdt_expired_o=0.
- Access 0x18 and 0x20 -> pslverr=1, prdata=0, no register changes. Assert reset_n low mid-write to STATUS -> all outputs return to reset values.
